// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with a single-outstanding memory request and a prefetch queue.
// Branch redirects flush the queue and drop any response still in flight.
module instr_fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PC_STEP     = 1,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           branch_en,
  input  logic [ADDR_WIDTH-1:0]          branch_addr,
  output logic                           mem_req,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic                           mem_ack,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic [DATA_WIDTH-1:0]          instr_out,
  output logic [ADDR_WIDTH-1:0]          pc_out,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q;
  logic [CNT_W-1:0]        count_q;
  logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
  logic [DATA_WIDTH-1:0]   data_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_q   [QUEUE_DEPTH];

  logic                    push, pop, stay_req;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [CNT_W:0]          occ_next;

  always_comb begin
    instr_valid = (count_q != '0);
    instr_out   = data_q[rd_ptr_q];
    pc_out      = pc_q[rd_ptr_q];
    queue_count = count_q;
    push        = (state_q == StReq) && mem_ack && !branch_en;
    pop         = instr_valid && instr_ready && !branch_en;
    next_addr   = mem_addr + ADDR_WIDTH'(PC_STEP);
    // Occupancy after this edge if the pending response is pushed.
    occ_next    = {1'b0, count_q} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
    stay_req    = occ_next < (CNT_W+1)'(QUEUE_DEPTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      mem_req    <= 1'b0;
      mem_addr   <= ADDR_WIDTH'(RESET_PC);
      fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
    end else begin
      if (branch_en) fetch_pc_q <= branch_addr;
      case (state_q)
        StIdle: begin
          if (!branch_en && count_q < CNT_W'(QUEUE_DEPTH)) begin
            state_q  <= StReq;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc_q;
          end
        end
        StReq: begin
          if (branch_en) begin
            if (mem_ack) begin
              state_q <= StIdle;
              mem_req <= 1'b0;
            end else begin
              state_q <= StDrop;
            end
          end else if (mem_ack) begin
            fetch_pc_q <= next_addr;
            if (stay_req) begin
              mem_addr <= next_addr;
            end else begin
              state_q <= StIdle;
              mem_req <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (mem_ack) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (branch_en) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata;
        pc_q[wr_ptr_q]   <= mem_addr;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a latency-configurable memory responder.
// Memory returns rdata = addr*3; inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_en;
  logic [7:0]  branch_addr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic [2:0]  queue_count;

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 0;
  logic [3:0] age;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .queue_count (queue_count)
  );

  // Ack once the current request has been held for lat cycles.
  assign mem_ack   = mem_req && (int'(age) >= lat);
  assign mem_rdata = 32'(mem_addr) * 32'd3;

  always @(posedge clk or posedge reset) begin
    if (reset) age <= '0;
    else if (mem_req && !mem_ack) age <= age + 4'd1;
    else age <= '0;
  end

  task automatic do_reset(input int l, input logic rdy);
    @(negedge clk);
    reset = 1'b1; branch_en = 1'b0; branch_addr = '0; lat = l; instr_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; branch_en = 1'b0; branch_addr = '0; lat = 0; instr_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h want 0", instr_valid); end
    n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0h want 0", queue_count); end
    n_cmp++; if (instr_out !== 32'd0 || pc_out !== 8'd0) begin
      n_err++; $display("FAIL reset_head: got %0h/%0h want 0/0", instr_out, pc_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset(0, 1'b1);
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_start: got req=%0h addr=%0h vld=%0h want 1/0/0", mem_req, mem_addr, instr_valid);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 8'(k) || instr_out !== 32'(k * 3)
                   || queue_count !== 3'd1) begin
        n_err++; $display("FAIL stream_%0d: got vld=%0h pc=%0h instr=%0h cnt=%0h want 1/%0h/%0h/1",
                          k, instr_valid, pc_out, instr_out, queue_count, k, k * 3);
      end
    end
  endtask

  task automatic test_full_drain();
    int exp_pc;
    int guard;
    do_reset(2, 1'b0);
    guard = 0;
    while (queue_count !== 3'd4 && guard < 40) begin @(negedge clk); guard++; end
    n_cmp++; if (queue_count !== 3'd4) begin n_err++; $display("FAIL full_reach: got %0h want 4", queue_count); end
    repeat (5) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || queue_count !== 3'd4) begin
      n_err++; $display("FAIL full_hold: got req=%0h cnt=%0h want 0/4", mem_req, queue_count);
    end
    n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 8'h00 || instr_out !== 32'h0) begin
      n_err++; $display("FAIL full_head: got vld=%0h pc=%0h instr=%0h want 1/0/0", instr_valid, pc_out, instr_out);
    end
    instr_ready = 1'b1;
    exp_pc = 0;
    guard  = 0;
    while (exp_pc < 6 && guard < 80) begin
      if (instr_valid === 1'b1) begin
        n_cmp++; if (pc_out !== 8'(exp_pc) || instr_out !== 32'(exp_pc * 3)) begin
          n_err++; $display("FAIL drain_%0d: got pc=%0h instr=%0h want %0h/%0h",
                            exp_pc, pc_out, instr_out, exp_pc, exp_pc * 3);
        end
        exp_pc++;
      end
      @(negedge clk); guard++;
    end
    n_cmp++; if (exp_pc != 6) begin n_err++; $display("FAIL drain_timeout: got %0d entries want 6", exp_pc); end
  endtask

  task automatic test_branch_drop();
    int guard;
    do_reset(3, 1'b1);
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_ack !== 1'b0) begin
      n_err++; $display("FAIL drop_pending: got req=%0h ack=%0h want 1/0", mem_req, mem_ack);
    end
    branch_en = 1'b1; branch_addr = 8'h40;
    @(negedge clk);
    branch_en = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || queue_count !== 3'd0) begin
      n_err++; $display("FAIL drop_hold: got req=%0h addr=%0h cnt=%0h want 1/0/0", mem_req, mem_addr, queue_count);
    end
    guard = 0;
    while (instr_valid !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 8'h40 || instr_out !== 32'hC0) begin
      n_err++; $display("FAIL drop_first: got vld=%0h pc=%0h instr=%0h want 1/40/c0", instr_valid, pc_out, instr_out);
    end
  endtask

  task automatic test_branch_push_pop();
    do_reset(0, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if (pc_out !== 8'h02 || mem_ack !== 1'b1 || queue_count !== 3'd1) begin
      n_err++; $display("FAIL bpp_pre: got pc=%0h ack=%0h cnt=%0h want 2/1/1", pc_out, mem_ack, queue_count);
    end
    branch_en = 1'b1; branch_addr = 8'h20;
    @(negedge clk);
    branch_en = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || queue_count !== 3'd0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL bpp_flush: got vld=%0h cnt=%0h req=%0h want 0/0/0", instr_valid, queue_count, mem_req);
    end
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h20) begin
      n_err++; $display("FAIL bpp_req: got req=%0h addr=%0h want 1/20", mem_req, mem_addr);
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 8'h20 || instr_out !== 32'h60) begin
      n_err++; $display("FAIL bpp_first: got vld=%0h pc=%0h instr=%0h want 1/20/60", instr_valid, pc_out, instr_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_pc [4];
    logic [31:0] exp_in [4];
    int idx;
    int guard;
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
    exp_in[0] = 32'h2FA; exp_in[1] = 32'h2FD; exp_in[2] = 32'h0; exp_in[3] = 32'h3;
    do_reset(0, 1'b1);
    branch_en = 1'b1; branch_addr = 8'hFE;
    @(negedge clk);
    branch_en = 1'b0;
    idx = 0; guard = 0;
    while (idx < 4 && guard < 20) begin
      if (instr_valid === 1'b1) begin
        n_cmp++; if (pc_out !== exp_pc[idx] || instr_out !== exp_in[idx]) begin
          n_err++; $display("FAIL wrap_%0d: got pc=%0h instr=%0h want %0h/%0h",
                            idx, pc_out, instr_out, exp_pc[idx], exp_in[idx]);
        end
        idx++;
      end
      @(negedge clk); guard++;
    end
    n_cmp++; if (idx != 4) begin n_err++; $display("FAIL wrap_timeout: got %0d entries want 4", idx); end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset(2, 1'b0);
    guard = 0;
    while (queue_count !== 3'd3 && guard < 40) begin @(negedge clk); guard++; end
    n_cmp++; if (queue_count !== 3'd3 || mem_req !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: got cnt=%0h req=%0h want 3/1", queue_count, mem_req);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || queue_count !== 3'd0 || mem_addr !== 8'h00) begin
      n_err++; $display("FAIL areset_now: got req=%0h vld=%0h cnt=%0h addr=%0h want 0/0/0/0",
                        mem_req, instr_valid, queue_count, mem_addr);
    end
    lat = 0; instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    guard = 0;
    while (instr_valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    n_cmp++; if (instr_valid !== 1'b1 || pc_out !== 8'h00 || instr_out !== 32'h0) begin
      n_err++; $display("FAIL areset_restart: got vld=%0h pc=%0h instr=%0h want 1/0/0", instr_valid, pc_out, instr_out);
    end
  endtask

  initial begin
    reset = 1'b1; branch_en = 1'b0; branch_addr = '0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_full_drain();
    test_branch_drop();
    test_branch_push_pop();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
